panda_load_store_unit_mc: RTL and testbench
===========================================

// Module: panda_load_store_unit_mc
// PURPOSE
//  Multi-cycle load/store unit: accepts one load/store from the core, runs it over a req/gnt/rvalid data bus.
//  Generates byte enables, aligns store data, extracts and sign/zero-extends load data, and reports errors.
//  Sits between execute stage and data memory or interconnect; core stalls while lsu_ready_o is low.
// PARAMETERS
//  TimeoutCycles  255  cycles one bus transaction may wait for gnt+rvalid before abort; 0 = no timeout
//  CntWidth       8    width of timeout counter; must hold TimeoutCycles
// PORTS
//  clk_i           in   1   clock
//  rst_ni          in   1   asynchronous active-low reset
//  lsu_req_i       in   1   core request, sampled only when lsu_ready_o=1
//  lsu_we_i        in   1   1 = store
//  lsu_unsigned_i  in   1   1 = zero-extend load
//  lsu_width_i     in   2   00 byte, 01 half, 10 word, 11 illegal
//  lsu_addr_i      in   32  byte address
//  lsu_wdata_i     in   32  store data, LSBs significant
//  lsu_ready_o     out  1   FSM in IDLE, request accepted this cycle
//  lsu_valid_o     out  1   one-cycle completion pulse (loads and stores)
//  lsu_rdata_o     out  32  extended load data, valid with lsu_valid_o; 0 for stores
//  lsu_err_o       out  1   error qualifier, valid with lsu_valid_o
//  data_req_o      out  1   bus request, held until data_gnt_i
//  data_gnt_i      in   1   bus grant
//  data_addr_o     out  32  word-aligned bus address
//  data_we_o       out  1   bus write
//  data_be_o       out  4   byte enables
//  data_wdata_o    out  32  lane-aligned write data
//  data_rvalid_i   in   1   bus response
//  data_rdata_i    in   32  bus read data
//  data_err_i      in   1   bus error, valid with data_rvalid_i
// BEHAVIOUR
//  Reset: state IDLE; lsu_ready_o=1; all other outputs 0; counter and latched request cleared. Reset mid-operation drops the transaction.
//  Accept cycle T: IDLE & lsu_req_i -> latch we/unsigned/width/addr/wdata, go REQ. data_req_o registered, high from T+1.
//  REQ: data_req_o=1; addr/we/be/wdata stable until gnt. gnt -> WAIT. WAIT: rvalid -> capture rdata, finish or next phase.
//  Min latency: gnt at T+1, rvalid at T+2 -> lsu_valid_o at T+3. lsu_valid_o/rdata/err registered, one-cycle pulse, return to IDLE same cycle.
//  Byte enables: base = 0001/0011/1111 per width, shifted left by addr[1:0] into 8 bits; be_lo=[3:0], be_hi=[7:4].
//  Write data: replicate-free shift, {32'b0,wdata} << 8*addr[1:0]; lo/hi words map to the two phases.
//  Load: {rdata_hi,rdata_lo} >> 8*addr[1:0], take byte/half/word, sign-extend unless lsu_unsigned_i.
//  Width 11: no bus transaction; lsu_valid_o+lsu_err_o at T+1.
//  data_err_i with rvalid: abort remaining phases, lsu_valid_o+lsu_err_o, lsu_rdata_o=0.
//  Timeout: counter clears on each phase start, increments in REQ/WAIT; reaching TimeoutCycles -> drop data_req_o, IDLE path with err.
//  data_rvalid_i in IDLE or REQ is ignored (stray response after timeout).
// CONFIGURATION
//  PANDA_LSU_MISALIGNED_EN defined: be_hi!=0 -> two phases: addr&~3 with be_lo (skipped if be_lo==0), then (addr&~3)+4 with be_hi; rvalid of phase 1 stored as rdata_lo.
//  Not defined: any access with be_hi!=0 (half at offset 3, word at offset !=0) -> no bus transaction, err pulse at T+1. Half at offset 1 is single-phase in both modes.
// STRUCTURE
//  panda_pkg: lsu_width_e {LSU_BYTE, LSU_HALF, LSU_WORD}; lsu_state_e {IDLE, REQ, WAIT, DONE}; LSU_BE_BYTE/HALF/WORD constants.
//  Sub-module panda_lsu_align (combinational): width+offset+wdata -> 8-bit be, 64-bit shifted wdata; 64-bit rdata -> extended result.
//  Top holds FSM, phase flag, timeout counter, latched request, registered core outputs.
// TESTING
//  lb addr=0x103, rdata=0x80FF_0000, unsigned=0 -> data_be_o=1000, lsu_rdata_o=0xFFFF_FF80, valid at T+3 with gnt immediate.
//  sh addr=0x202, wdata=0x0000_ABCD -> data_be_o=1100, data_wdata_o=0xABCD_0000, data_addr_o=0x200.
//  lw addr=0x301, MISALIGNED_EN: rdata 0x44332211 then 0x88776655 -> addrs 0x300/0x304, be 1110/0001, result 0x55443322.
//  lw addr=0x301 without macro -> no data_req_o, lsu_valid_o+lsu_err_o at T+1.
//  data_gnt_i held low, TimeoutCycles=4 -> data_req_o drops, lsu_err_o pulse, later rvalid ignored, next request accepted.
//  gnt delayed 3 cycles then data_err_i on rvalid -> addr/be stable while waiting; err pulse; rst_ni low mid-WAIT -> outputs 0, IDLE.

Source files
------------

// File: rtl/panda_pkg.sv
// Shared types, byte-enable constants and the byte-enable helper for the
// panda load/store unit.
package panda_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_width_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    localparam logic [3:0] LSU_BE_BYTE = 4'b0001;
    localparam logic [3:0] LSU_BE_HALF = 4'b0011;
    localparam logic [3:0] LSU_BE_WORD = 4'b1111;

    // 8-bit enable window spanning the addressed word and the one after it.
    function automatic logic [7:0] lsu_be8(input logic [1:0] width, input logic [1:0] offset);
        logic [3:0] base;
        case (width)
            LSU_BYTE: base = LSU_BE_BYTE;
            LSU_HALF: base = LSU_BE_HALF;
            LSU_WORD: base = LSU_BE_WORD;
            default:  base = 4'b0000;
        endcase
        return {4'b0000, base} << offset;
    endfunction

endpackage

// File: rtl/panda_load_store_unit_mc_if.sv
// Data-bus bundle (req/gnt/rvalid) between the load/store unit and memory.
interface panda_load_store_unit_mc_if;
    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );
endinterface

// File: rtl/panda_lsu_align.sv
// Combinational lane alignment: byte enables and shifted store data from
// width/offset, and extraction plus sign/zero extension of load data.
module panda_lsu_align
    import panda_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] rdata_i,
    input  logic        unsigned_i,
    output logic [7:0]  be_o,
    output logic [63:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] rdata_shift;

    assign be_o        = lsu_be8(width_i, offset_i);
    assign wdata_o     = {32'b0, wdata_i} << {offset_i, 3'b000};
    assign rdata_shift = 32'(rdata_i >> {offset_i, 3'b000});

    always_comb begin
        rdata_o = rdata_shift;
        case (width_i)
            LSU_BYTE: rdata_o = {{24{~unsigned_i & rdata_shift[7]}}, rdata_shift[7:0]};
            LSU_HALF: rdata_o = {{16{~unsigned_i & rdata_shift[15]}}, rdata_shift[15:0]};
            default:  rdata_o = rdata_shift;
        endcase
    end

endmodule

// File: rtl/panda_load_store_unit_mc.sv
// Multi-cycle load/store unit between execute stage and a req/gnt/rvalid bus.
// PANDA_LSU_MISALIGNED_EN: split word-crossing accesses into two bus phases.
//
// state | meaning
// IDLE  | ready for a core request; completion pulses are issued from here
// REQ   | data_req_o high, waiting for grant
// WAIT  | granted, waiting for rvalid
// DONE  | unused encoding, falls back to IDLE
module panda_load_store_unit_mc
    import panda_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255,
    parameter int unsigned CntWidth      = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic        lsu_unsigned_i,
    input  logic [1:0]  lsu_width_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_ready_o,
    output logic        lsu_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    panda_load_store_unit_mc_if.master bus
);

    localparam bit                TmoEn    = (TimeoutCycles != 0);
    localparam logic [CntWidth:0] TmoLimit = (CntWidth + 1)'(TimeoutCycles);

    lsu_state_e        state_q, state_d;
    logic              phase_q, phase_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              unsigned_q, unsigned_d;
    logic [1:0]        width_q, width_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_lo_q, rdata_lo_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [7:0]        acc_be8;
    logic              acc_bad;
    logic              acc_skip_lo;
    logic [7:0]        be8;
    logic [63:0]       wdata64;
    logic [63:0]       rdata64;
    logic [31:0]       ld_result;
    logic              last_phase;
    logic [CntWidth:0] cnt_inc;
    logic              tmo_hit;

    assign acc_be8     = lsu_be8(lsu_width_i, lsu_addr_i[1:0]);
    assign acc_skip_lo = (acc_be8[3:0] == 4'b0000) && (acc_be8[7:4] != 4'b0000);

`ifdef PANDA_LSU_MISALIGNED_EN
    assign acc_bad = (lsu_width_i == 2'b11);
`else
    // Word-crossing accesses cannot be split in this build, so they fail fast.
    assign acc_bad = (lsu_width_i == 2'b11) || (acc_be8[7:4] != 4'b0000);
`endif

    assign rdata64    = phase_q ? {bus.data_rdata, rdata_lo_q} : {32'b0, bus.data_rdata};
    assign last_phase = phase_q || (be8[7:4] == 4'b0000);
    assign cnt_inc    = {1'b0, cnt_q} + (CntWidth + 1)'(1);
    assign tmo_hit    = TmoEn && (cnt_inc >= TmoLimit);

    panda_lsu_align u_align (
        .width_i   (width_q),
        .offset_i  (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (rdata64),
        .unsigned_i(unsigned_q),
        .be_o      (be8),
        .wdata_o   (wdata64),
        .rdata_o   (ld_result)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        unsigned_d = unsigned_q;
        width_d    = width_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_lo_d = rdata_lo_q;
        req_d      = req_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = 32'b0;

        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    we_d       = lsu_we_i;
                    unsigned_d = lsu_unsigned_i;
                    width_d    = lsu_width_i;
                    addr_d     = lsu_addr_i;
                    wdata_d    = lsu_wdata_i;
                    rdata_lo_d = 32'b0;
                    cnt_d      = '0;
                    if (acc_bad) begin
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        phase_d = acc_skip_lo;
                    end
                end
            end
            REQ: begin
                if (bus.data_gnt) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                    cnt_d   = cnt_inc[CntWidth-1:0];
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc[CntWidth-1:0];
                end
            end
            WAIT: begin
                if (bus.data_rvalid) begin
                    if (bus.data_err) begin
                        state_d = IDLE;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (last_phase) begin
                        state_d = IDLE;
                        valid_d = 1'b1;
                        rdata_d = we_q ? 32'b0 : ld_result;
                    end else begin
                        // Low word captured; reissue for the upper word.
                        state_d    = REQ;
                        rdata_lo_d = bus.data_rdata;
                        phase_d    = 1'b1;
                        req_d      = 1'b1;
                        cnt_d      = '0;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc[CntWidth-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            width_q    <= 2'b00;
            addr_q     <= 32'b0;
            wdata_q    <= 32'b0;
            rdata_lo_q <= 32'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            unsigned_q <= unsigned_d;
            width_q    <= width_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_lo_q <= rdata_lo_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign lsu_ready_o = (state_q == IDLE);
    assign lsu_valid_o = valid_q;
    assign lsu_err_o   = err_q;
    assign lsu_rdata_o = rdata_q;

    // Bus fields are only driven while a request is outstanding.
    assign bus.data_req   = req_q;
    assign bus.data_we    = req_q & we_q;
    assign bus.data_addr  = req_q ? {addr_q[31:2] + 30'(phase_q), 2'b00} : 32'b0;
    assign bus.data_be    = req_q ? (phase_q ? be8[7:4] : be8[3:0]) : 4'b0000;
    assign bus.data_wdata = req_q ? (phase_q ? wdata64[63:32] : wdata64[31:0]) : 32'b0;

endmodule

// File: tb/tb_panda_load_store_unit_mc.sv
// Self-checking bench for panda_load_store_unit_mc: directed cases plus random
// loads/stores checked against a byte-lane reference model.
module tb_panda_load_store_unit_mc;

    localparam int TMO = 4;
`ifdef PANDA_LSU_MISALIGNED_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_req_i, lsu_we_i, lsu_unsigned_i;
    logic [1:0]  lsu_width_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_ready_o, lsu_valid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;

    int vectors     = 0;
    int miscompares = 0;

    panda_load_store_unit_mc_if bus ();

    panda_load_store_unit_mc #(.TimeoutCycles(TMO), .CntWidth(8)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .lsu_req_i     (lsu_req_i),
        .lsu_we_i      (lsu_we_i),
        .lsu_unsigned_i(lsu_unsigned_i),
        .lsu_width_i   (lsu_width_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_valid_o   (lsu_valid_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .lsu_err_o     (lsu_err_o),
        .bus           (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One core operation with a lockstep memory responder. err_at selects the
    // phase (0/1) whose rvalid carries data_err_i, -1 for none.
    task automatic run_op(input string tag, input logic we, input logic uns,
                          input logic [1:0] width, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd0,
                          input logic [31:0] rd1, input int gd, input int rdl,
                          input int err_at);
        int          nbytes;
        logic [7:0]  be8;
        logic [63:0] w64, r64;
        logic [31:0] v, exp_r, base_addr;
        logic        illegal;
        int          first, last;

        nbytes    = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
        be8       = 8'(((1 << nbytes) - 1) << addr[1:0]);
        illegal   = (width == 2'd3) || (!MIS && be8[7:4] != 4'h0);
        w64       = {32'b0, wdata} << {addr[1:0], 3'b000};
        r64       = {rd1, rd0};
        v         = 32'(r64 >> {addr[1:0], 3'b000});
        base_addr = addr & 32'hFFFF_FFFC;
        if (nbytes == 1)      exp_r = uns ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        else if (nbytes == 2) exp_r = uns ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        else                  exp_r = v;
        if (we) exp_r = 32'b0;

        check({tag, "_ready"}, lsu_ready_o, 1'b1);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_unsigned_i = uns;
        lsu_width_i = width; lsu_addr_i = addr; lsu_wdata_i = wdata;
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        lsu_addr_i = $urandom; lsu_wdata_i = $urandom;

        if (illegal) begin
            check({tag, "_ill_valid"}, lsu_valid_o, 1'b1);
            check({tag, "_ill_err"}, lsu_err_o, 1'b1);
            check({tag, "_ill_req"}, bus.data_req, 1'b0);
            @(negedge clk_i);
            return;
        end
        check({tag, "_early_valid"}, lsu_valid_o, 1'b0);

        first = (be8[3:0] != 4'h0) ? 0 : 1;
        last  = (be8[7:4] != 4'h0) ? 1 : 0;
        for (int p = first; p <= last; p++) begin
            for (int k = 0; k <= gd; k++) begin
                check({tag, "_req"}, bus.data_req, 1'b1);
                check({tag, "_addr"}, bus.data_addr, base_addr + 32'(4 * p));
                check({tag, "_be"}, bus.data_be, p ? be8[7:4] : be8[3:0]);
                check({tag, "_we"}, bus.data_we, we);
                if (we) check({tag, "_wdata"}, bus.data_wdata, p ? w64[63:32] : w64[31:0]);
                bus.data_gnt = (k == gd);
                @(negedge clk_i);
            end
            bus.data_gnt = 1'b0;
            check({tag, "_req_drop"}, bus.data_req, 1'b0);
            repeat (rdl) @(negedge clk_i);
            bus.data_rvalid = 1'b1;
            bus.data_rdata  = p ? rd1 : rd0;
            bus.data_err    = (err_at == p);
            @(negedge clk_i);
            bus.data_rvalid = 1'b0;
            bus.data_err    = 1'b0;
            bus.data_rdata  = $urandom;
            if (err_at == p) begin
                check({tag, "_buserr_valid"}, lsu_valid_o, 1'b1);
                check({tag, "_buserr_err"}, lsu_err_o, 1'b1);
                check({tag, "_buserr_rdata"}, lsu_rdata_o, 32'b0);
                return;
            end
        end
        check({tag, "_valid"}, lsu_valid_o, 1'b1);
        check({tag, "_err"}, lsu_err_o, 1'b0);
        check({tag, "_rdata"}, lsu_rdata_o, exp_r);
    endtask

    // Request with gnt withheld (or rvalid withheld after an immediate gnt);
    // the unit must give up after TMO cycles in the phase and ignore a late rvalid.
    task automatic tmo_test(input string tag, input bit gnt_now);
        int req_cycles = 0;
        int vcyc       = -1;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_unsigned_i = 1'b0;
        lsu_width_i = 2'd2; lsu_addr_i = 32'h0000_0100;
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        for (int c = 0; c < TMO + 4; c++) begin
            if (bus.data_req) req_cycles++;
            if (lsu_valid_o && vcyc < 0) begin
                vcyc = c;
                check({tag, "_err"}, lsu_err_o, 1'b1);
            end
            bus.data_gnt = gnt_now && (c == 0);
            @(negedge clk_i);
        end
        bus.data_gnt = 1'b0;
        check({tag, "_req_cycles"}, 64'(req_cycles), gnt_now ? 64'd1 : 64'(TMO));
        check({tag, "_valid_cycle"}, 64'(vcyc), 64'(TMO));
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = 32'hDEAD_BEEF;
        @(negedge clk_i);
        bus.data_rvalid = 1'b0;
        check({tag, "_stray_valid"}, lsu_valid_o, 1'b0);
        check({tag, "_stray_req"}, bus.data_req, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_unsigned_i = 1'b0;
        lsu_width_i = 2'd0; lsu_addr_i = 32'b0; lsu_wdata_i = 32'b0;
        bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0;
        bus.data_rdata = 32'b0; bus.data_err = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", lsu_ready_o, 1'b1);
        check("rst_valid", lsu_valid_o, 1'b0);
        check("rst_err", lsu_err_o, 1'b0);
        check("rst_rdata", lsu_rdata_o, 32'b0);
        check("rst_req", bus.data_req, 1'b0);
        check("rst_be", bus.data_be, 4'b0);
        check("rst_addr", bus.data_addr, 32'b0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_op("lb103", 1'b0, 1'b0, 2'd0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 32'h0, 0, 0, -1);
        run_op("sh202", 1'b1, 1'b0, 2'd1, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 32'h0, 0, 0, -1);
        run_op("lw301", 1'b0, 1'b0, 2'd2, 32'h0000_0301, 32'h0, 32'h4433_2211, 32'h8877_6655, 0, 0, -1);
        run_op("lhu201", 1'b0, 1'b1, 2'd1, 32'h0000_0201, 32'h0, 32'h00F0_8700, 32'h0, 1, 1, -1);
        run_op("lh303", 1'b0, 1'b0, 2'd1, 32'h0000_0303, 32'h0, 32'h99AA_BBCC, 32'h1122_3380, 0, 1, -1);
        run_op("ill_w", 1'b0, 1'b0, 2'd3, 32'h0000_0400, 32'h0, 32'h0, 32'h0, 0, 0, -1);
        run_op("gnt3_err", 1'b1, 1'b0, 2'd2, 32'h0000_0500, 32'h1234_5678, 32'h0, 32'h0, 3, 0, 0);

        tmo_test("tmo_req", 1'b0);
        run_op("after_tmo", 1'b0, 1'b1, 2'd0, 32'h0000_0602, 32'h0, 32'h00C3_0000, 32'h0, 0, 0, -1);
        tmo_test("tmo_wait", 1'b1);

        // Reset while waiting for rvalid drops the transaction.
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_width_i = 2'd2;
        lsu_addr_i = 32'h0000_0040; lsu_wdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        bus.data_gnt = 1'b1;
        @(negedge clk_i);
        bus.data_gnt = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("midrst_ready", lsu_ready_o, 1'b1);
        check("midrst_valid", lsu_valid_o, 1'b0);
        check("midrst_req", bus.data_req, 1'b0);
        check("midrst_wdata", bus.data_wdata, 32'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        bus.data_rvalid = 1'b1;
        @(negedge clk_i);
        bus.data_rvalid = 1'b0;
        check("midrst_stray", lsu_valid_o, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] w;
            int gd, rdl, ea;
            w   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            gd  = $urandom_range(0, 2);
            rdl = $urandom_range(0, 2 - gd);
            ea  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : -1;
            run_op("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w,
                   $urandom, $urandom, $urandom, $urandom, gd, rdl, ea);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
